ext_arbiter: RTL and testbench
==============================

# ext_arbiter

Shared immediate-extension unit with a two-requester arbiter for the five-stage pipeline. Port 0 is the decode stage and port 1 is the branch-target unit. Each request carries a 16-bit immediate and a 2-bit extension opcode. The block grants one request per cycle using round-robin arbitration, performs the extension, and holds the 32-bit result in a single-entry output register until the consumer accepts it.

## Interface
- STALL_W, default 16: width of the stall counter (compiled in only with the perf macro).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  decode stage request valid.
- req0_imm  input  16  decode stage immediate.
- req0_extop  input  2  decode stage extension opcode.
- req0_ready  output  1  decode stage request accepted this cycle.
- req1_valid  input  1  branch unit request valid.
- req1_imm  input  16  branch unit immediate.
- req1_extop  input  2  branch unit extension opcode.
- req1_ready  output  1  branch unit request accepted this cycle.
- res_valid  output  1  output register holds a result.
- res_data  output  32  extended result.
- res_src  output  1  source of the result: 0 = decode, 1 = branch.
- res_ready  input  1  consumer accepts the result.
- stall_cnt  output  STALL_W  perf counter; present only with EXT_ARB_PERF_EN.

## Operation
- Extension rules, selected by extop:
  - 00: zero-extend, {16'h0000, imm}.
  - 01: sign-extend, {{16{imm[15]}}, imm}.
  - 10: upper, {imm, 16'h0000}.
  - 11: zero-extend, same as 00.
- State machine, two states:
  - EMPTY: res_valid = 0.
  - FULL: res_valid = 1.
- can_load = (state == EMPTY) | res_ready.
- Grant logic, combinational, only when can_load = 1:
  - Exactly one request valid: grant it.
  - Both valid: grant the port opposite to last_grant.
  - Neither valid: no grant.
- reqN_ready = can_load & grant == N. At most one ready is high per cycle.
- On a grant, at the clock edge:
  - res_data and res_src load from the granted port.
  - state moves to FULL.
  - last_grant updates to the granted port.
- FULL with res_ready = 1 and no grant: state moves to EMPTY; res_data holds its last value.
- FULL with res_ready = 0: all outputs hold; both ready outputs are 0.
- FULL with res_ready = 1 and a grant in the same cycle: the result is replaced back-to-back and state stays FULL.
- last_grant changes only on a grant. A port that is not granted loses nothing; its requester keeps valid asserted.
- Request inputs may change freely while reqN_ready is 0. Only the values present in the granting cycle are captured.

## Timing
- Reset values:
  - state = EMPTY, res_valid = 0, res_data = 32'h0, res_src = 0.
  - last_grant = 1, so port 0 wins the first contention.
  - stall_cnt = 0.
- Latency: a grant in cycle N gives res_valid = 1 and the new res_data in cycle N+1.
- Throughput: one result per cycle while res_ready stays high.
- req*_ready depends combinationally on res_ready and the valid inputs. There is no path from ready back into valid.
- Fairness: under continuous dual requests, grants alternate 0,1,0,1 starting with 0 after reset. Any waiting requester is served within 2 grant opportunities.
- Reset asserted mid-operation: the held result is discarded immediately, asynchronously, and all state returns to reset values.

## Configuration
- EXT_ARB_PERF_EN:
  - Defined: stall_cnt exists. It increments once per cycle in which at least one reqN_valid = 1 and no grant occurs, or in which both ports are valid and one is refused. It saturates at all-ones and clears only on reset.
  - Undefined: the stall_cnt port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset, then req0_valid = 1, imm = 16'h8001, extop = 01, res_ready = 1 -> next cycle res_valid = 1, res_data = 32'hFFFF8001, res_src = 0.
- Both ports valid for 4 cycles, res_ready = 1 (req0: imm 16'h1234, extop 10; req1: imm 16'hF000, extop 00) -> res_src sequence 0,1,0,1; data alternates 32'h12340000 and 32'h0000F000.
- Result held with res_ready = 0 for 3 cycles while req1 is valid -> req0_ready = req1_ready = 0; res_data stable; with perf enabled, stall_cnt = 3.
- FULL with res_ready = 1 and req1_valid = 1, extop = 11, imm = 16'hFFFF in the same cycle -> no bubble; res_data = 32'h0000FFFF the next cycle.
- rst_n pulled low while FULL -> res_valid = 0 and res_data = 0 immediately; the first contention after release grants port 0.
- Perf enabled, STALL_W = 2, 5 stalled cycles -> stall_cnt saturates at 3.

Source files
------------

// File: rtl/ext_arbiter.sv
// rtl/ext_arbiter.sv - two-port round-robin immediate-extension unit with single-entry result register
// Optional stall counter port and logic enabled by defining EXT_ARB_PERF_EN.
module ext_arbiter
`ifdef EXT_ARB_PERF_EN
#(
    parameter int STALL_W = 16
)
`endif
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [15:0] req0_imm,
    input  logic [1:0]  req0_extop,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_imm,
    input  logic [1:0]  req1_extop,
    output logic        req1_ready,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic        res_src,
    input  logic        res_ready
`ifdef EXT_ARB_PERF_EN
    ,
    output logic [STALL_W-1:0] stall_cnt
`endif
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]  state;
    logic        last_grant;
    logic        can_load;
    logic        both_valid;
    logic        gnt_any;
    logic        gnt_port;
    logic [15:0] sel_imm;
    logic [1:0]  sel_extop;
    logic [31:0] ext_data;

    function automatic logic [31:0] extend(input logic [15:0] imm, input logic [1:0] op);
        case (op)
            2'b01:   extend = {{16{imm[15]}}, imm};
            2'b10:   extend = {imm, 16'h0000};
            default: extend = {16'h0000, imm};
        endcase
    endfunction

    // With both ports valid the port opposite to the last winner takes the slot.
    always_comb begin
        can_load   = (state == EMPTY) | res_ready;
        both_valid = req0_valid & req1_valid;
        gnt_any    = can_load & (req0_valid | req1_valid);
        gnt_port   = both_valid ? ~last_grant : req1_valid;
        req0_ready = gnt_any & ~gnt_port;
        req1_ready = gnt_any & gnt_port;
        sel_imm    = gnt_port ? req1_imm   : req0_imm;
        sel_extop  = gnt_port ? req1_extop : req0_extop;
        ext_data   = extend(sel_imm, sel_extop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            res_data   <= 32'h0;
            res_src    <= 1'b0;
            last_grant <= 1'b1;
        end else if (gnt_any) begin
            state      <= FULL;
            res_data   <= ext_data;
            res_src    <= gnt_port;
            last_grant <= gnt_port;
        end else if (res_ready) begin
            state <= EMPTY;
        end
    end

    assign res_valid = (state == FULL);

`ifdef EXT_ARB_PERF_EN
    logic stall;

    // A stall is any cycle where some valid requester walks away unserved.
    assign stall = (req0_valid | req1_valid) & (~can_load | both_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {STALL_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ext_arbiter.sv
// tb/tb_ext_arbiter.sv - table-driven self-checking bench for ext_arbiter
module tb_ext_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, res_ready;
    logic [15:0] req0_imm, req1_imm;
    logic [1:0]  req0_extop, req1_extop;
    logic        req0_ready, req1_ready, res_valid, res_src;
    logic [31:0] res_data;
    logic        s_req0_ready, s_req1_ready, s_res_valid, s_res_src;
    logic [31:0] s_res_data;
`ifdef EXT_ARB_PERF_EN
    logic [15:0] stall_cnt;
    logic [1:0]  sat_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ext_arbiter u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_imm(req0_imm), .req0_extop(req0_extop), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_imm(req1_imm), .req1_extop(req1_extop), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_data(res_data), .res_src(res_src), .res_ready(res_ready)
`ifdef EXT_ARB_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

`ifdef EXT_ARB_PERF_EN
    ext_arbiter #(.STALL_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_imm(req0_imm), .req0_extop(req0_extop), .req0_ready(s_req0_ready),
        .req1_valid(req1_valid), .req1_imm(req1_imm), .req1_extop(req1_extop), .req1_ready(s_req1_ready),
        .res_valid(s_res_valid), .res_data(s_res_data), .res_src(s_res_src), .res_ready(res_ready),
        .stall_cnt(sat_cnt)
    );
`endif

    typedef struct {
        logic        r0v;
        logic [15:0] r0i;
        logic [1:0]  r0o;
        logic        r1v;
        logic [15:0] r1i;
        logic [1:0]  r1o;
        logic        rr;
        logic        er0;
        logic        er1;
        logic        ev;
        logic [31:0] ed;
        logic        es;
        int          est;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [15:0] i0, input logic [1:0] o0,
                         input logic v1, input logic [15:0] i1, input logic [1:0] o1,
                         input logic rr);
        req0_valid = v0; req0_imm = i0; req0_extop = o0;
        req1_valid = v1; req1_imm = i1; req1_extop = o1;
        res_ready  = rr;
    endtask

    initial begin
        // r0v r0i r0o r1v r1i r1o rr | er0 er1 ev ed es est(cumulative stalls)
        vecs[0]  = '{1'b1, 16'h1234, 2'b10, 1'b1, 16'hF000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 32'h12340000, 1'b0, 1};
        vecs[1]  = '{1'b1, 16'h1234, 2'b10, 1'b1, 16'hF000, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000F000, 1'b1, 2};
        vecs[2]  = '{1'b1, 16'h1234, 2'b10, 1'b1, 16'hF000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 32'h12340000, 1'b0, 3};
        vecs[3]  = '{1'b1, 16'h1234, 2'b10, 1'b1, 16'hF000, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000F000, 1'b1, 4};
        vecs[4]  = '{1'b1, 16'h8001, 2'b01, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF8001, 1'b0, 4};
        vecs[5]  = '{1'b0, 16'h0000, 2'b00, 1'b1, 16'h5555, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF8001, 1'b0, 5};
        vecs[6]  = '{1'b0, 16'h0000, 2'b00, 1'b1, 16'h6666, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF8001, 1'b0, 6};
        vecs[7]  = '{1'b0, 16'h0000, 2'b00, 1'b1, 16'h7777, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF8001, 1'b0, 7};
        vecs[8]  = '{1'b0, 16'h0000, 2'b00, 1'b1, 16'hFFFF, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000FFFF, 1'b1, 7};
        vecs[9]  = '{1'b0, 16'h0000, 2'b00, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000FFFF, 1'b1, 7};
        vecs[10] = '{1'b1, 16'hABCD, 2'b10, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 32'hABCD0000, 1'b0, 7};
        vecs[11] = '{1'b1, 16'h7FFF, 2'b01, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00007FFF, 1'b0, 7};

        rst_n = 1'b0;
        drive(1'b0, 16'h0, 2'b0, 1'b0, 16'h0, 2'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("reset_res_valid", {31'b0, res_valid}, 32'h0);
        chk("reset_res_data", res_data, 32'h0);
        chk("reset_res_src", {31'b0, res_src}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].r0v, vecs[i].r0i, vecs[i].r0o, vecs[i].r1v, vecs[i].r1i, vecs[i].r1o, vecs[i].rr);
            #1;
            chk($sformatf("v%0d_req0_ready", i), {31'b0, req0_ready}, {31'b0, vecs[i].er0});
            chk($sformatf("v%0d_req1_ready", i), {31'b0, req1_ready}, {31'b0, vecs[i].er1});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_res_valid", i), {31'b0, res_valid}, {31'b0, vecs[i].ev});
            chk($sformatf("v%0d_res_data", i), res_data, vecs[i].ed);
            chk($sformatf("v%0d_res_src", i), {31'b0, res_src}, {31'b0, vecs[i].es});
`ifdef EXT_ARB_PERF_EN
            chk($sformatf("v%0d_stall_cnt", i), {16'b0, stall_cnt}, vecs[i].est);
            chk($sformatf("v%0d_stall_sat", i), {30'b0, sat_cnt}, (vecs[i].est > 3) ? 3 : vecs[i].est);
`endif
        end

        // Asynchronous reset while FULL, then first contention must go to port 0.
        @(negedge clk);
        drive(1'b0, 16'h0, 2'b0, 1'b0, 16'h0, 2'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_res_valid", {31'b0, res_valid}, 32'h0);
        chk("async_rst_res_data", res_data, 32'h0);
        chk("async_rst_res_src", {31'b0, res_src}, 32'h0);
`ifdef EXT_ARB_PERF_EN
        chk("async_rst_stall_cnt", {16'b0, stall_cnt}, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 16'h0001, 2'b00, 1'b1, 16'h0002, 2'b00, 1'b1);
        #1;
        chk("post_rst_req0_ready", {31'b0, req0_ready}, 32'h1);
        chk("post_rst_req1_ready", {31'b0, req1_ready}, 32'h0);
        @(posedge clk);
        #1;
        chk("post_rst_res_src", {31'b0, res_src}, 32'h0);
        chk("post_rst_res_data", res_data, 32'h00000001);
        @(negedge clk);
        drive(1'b0, 16'h0, 2'b0, 1'b0, 16'h0, 2'b0, 1'b1);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
